// File: rtl/ps2_rx_fifo_if.sv
// Consumer-side bus of the PS/2 receiver: show-ahead byte, pop strobe and status.
// Optional occupancy output when PS2_RX_FIFO_LEVEL_EN is defined.
interface ps2_rx_fifo_if
`ifdef PS2_RX_FIFO_LEVEL_EN
    #(parameter int FIFO_DEPTH = 8)
`endif
;
    logic       pop;
    logic [7:0] data;
    logic       ready;
    logic       overflow;
    logic       frame_err;
`ifdef PS2_RX_FIFO_LEVEL_EN
    localparam int LW = $clog2(FIFO_DEPTH) + 1;
    logic [LW-1:0] level;
`endif

    modport master (
        input  pop,
        output data, ready, overflow, frame_err
`ifdef PS2_RX_FIFO_LEVEL_EN
        , output level
`endif
    );

    modport slave (
        output pop,
        input  data, ready, overflow, frame_err
`ifdef PS2_RX_FIFO_LEVEL_EN
        , input level
`endif
    );
endinterface

// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver: synchronise, deserialise 11-bit frames, buffer good bytes.
// Optional occupancy output guarded by the PS2_RX_FIFO_LEVEL_EN macro.
module ps2_rx_fifo #(
    parameter int FIFO_DEPTH     = 8,
    parameter int TIMEOUT_CYCLES = 5000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ps2_clk,
    input  logic         ps2_data,
    ps2_rx_fifo_if.master bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [2:0]    clk_sync_q, clk_sync_d;
    logic [1:0]    dat_sync_q, dat_sync_d;
    logic [10:0]   shift_q, shift_d;
    logic [3:0]    bit_cnt_q, bit_cnt_d;
    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic          overflow_q, overflow_d;
    logic          frame_err_q, frame_err_d;
    logic [7:0]    mem_q [FIFO_DEPTH];

    logic fall;
    logic data_bit;
    logic frame_done;
    logic frame_ok;
    logic timeout;
    logic empty;
    logic full;
    logic pop_acc;
    logic push_acc;
    logic ovf_evt;

    // Flop 0 is the first synchroniser stage; a fall shows as stage1=0, stage2=1.
    always_comb begin
        clk_sync_d = {clk_sync_q[1:0], ps2_clk};
        dat_sync_d = {dat_sync_q[0], ps2_data};
        fall       = ~clk_sync_q[1] & clk_sync_q[2];
        data_bit   = dat_sync_q[1];
    end

    // Frame assembly: bits arrive LSB first, so they enter at the top and move down.
    always_comb begin
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        to_cnt_d   = to_cnt_q;
        frame_done = 1'b0;
        timeout    = 1'b0;
        if (bit_cnt_q == 4'd11) begin
            frame_done = 1'b1;
            bit_cnt_d  = 4'd0;
            to_cnt_d   = '0;
        end else if (fall) begin
            shift_d   = {data_bit, shift_q[10:1]};
            bit_cnt_d = bit_cnt_q + 4'd1;
            to_cnt_d  = '0;
        end else if (bit_cnt_q != 4'd0) begin
            if (to_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
                timeout   = 1'b1;
                bit_cnt_d = 4'd0;
                to_cnt_d  = '0;
            end else begin
                to_cnt_d = to_cnt_q + TW'(1);
            end
        end else begin
            to_cnt_d = '0;
        end
    end

    // Start low, stop high, odd parity across data plus parity bit.
    assign frame_ok = frame_done & ~shift_q[0] & shift_q[10] & (^shift_q[9:1]);

    always_comb begin
        empty    = (rd_ptr_q == wr_ptr_q);
        full     = (rd_ptr_q[AW-1:0] == wr_ptr_q[AW-1:0]) && (rd_ptr_q[AW] != wr_ptr_q[AW]);
        pop_acc  = bus.pop & ~empty;
        // A pop in the same cycle frees the slot, so a full FIFO still takes the byte.
        push_acc = frame_ok & (~full | pop_acc);
        ovf_evt  = frame_ok & full & ~pop_acc;

        wr_ptr_d = wr_ptr_q + PW'(push_acc);
        rd_ptr_d = rd_ptr_q + PW'(pop_acc);

        overflow_d = overflow_q;
        if (pop_acc) begin
            overflow_d = 1'b0;
        end
        if (ovf_evt) begin
            overflow_d = 1'b1;
        end

        frame_err_d = (frame_done & ~frame_ok) | timeout;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            clk_sync_q  <= 3'b111;
            dat_sync_q  <= 2'b11;
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            to_cnt_q    <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            overflow_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            clk_sync_q  <= clk_sync_d;
            dat_sync_q  <= dat_sync_d;
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            to_cnt_q    <= to_cnt_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            overflow_q  <= overflow_d;
            frame_err_q <= frame_err_d;
        end
    end

    // Storage carries no reset; the output gate below hides stale contents.
    always_ff @(posedge clk) begin
        if (push_acc) begin
            mem_q[wr_ptr_q[AW-1:0]] <= shift_q[8:1];
        end
    end

    assign bus.ready     = ~empty;
    assign bus.data      = empty ? 8'h00 : mem_q[rd_ptr_q[AW-1:0]];
    assign bus.overflow  = overflow_q;
    assign bus.frame_err = frame_err_q;

`ifdef PS2_RX_FIFO_LEVEL_EN
    logic [PW-1:0] level_q, level_d;

    assign level_d = wr_ptr_d - rd_ptr_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            level_q <= '0;
        end else begin
            level_q <= level_d;
        end
    end

    assign bus.level = level_q;
`endif
endmodule
